dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- Data-memory access stage directly downstream of the datapath ALU.
- Consumes the ALU result as the effective address and the rt value as store data.
- Performs word, halfword and byte loads/stores against an external memory port that may insert wait states.
- Stalls the single-cycle core until the access completes, then returns the aligned, extended load value for write-back.

Parameters:
N, 32, datapath/address width; only 32 is supported (4 byte lanes)
TIMEOUT, 16, max BUSY cycles without mem_ack before abort (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  current instruction is a load/store
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_unsigned  in  1  zero-extend loads (lbu/lhu)
addr  in  N  effective address (ALU result)
wdata  in  N  store data (rt)
stall  out  1  hold PC/instruction this cycle
done  out  1  one-cycle pulse, access complete
rdata  out  N  extended load result, valid while done=1
misalign  out  1  unaligned request rejected (combinational, IDLE only)
bus_err  out  1  timeout abort pulse (0 without feature)
mem_req  out  1  external request, registered
mem_we  out  1  external write enable
mem_addr  out  N  word-aligned address, {addr[N-1:2],2'b00}
mem_be  out  4  byte enables, little-endian lanes
mem_wdata  out  N  lane-replicated store data
mem_ack  in  1  external completion, one cycle
mem_rdata  in  N  external read word, valid with mem_ack

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset values: state=IDLE; all outputs 0, including mem_req/mem_we/mem_addr/mem_be/mem_wdata and rdata.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - misalign=1 only in IDLE with req_valid; no memory access; stall=0; state stays IDLE.
- IDLE:
  - On req_valid && !misalign: latch we/size/unsigned/addr[1:0]; register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata; go to BUSY.
  - stall=1 in that cycle.
- BUSY:
  - mem_req and all mem_* outputs held stable until mem_ack; stall=1.
  - On mem_ack: capture extended mem_rdata (loads) or 0 (stores) into rdata; clear mem_req at that edge; go to RESP.
  - mem_ack outside BUSY is ignored.
- RESP:
  - done=1, stall=0; the core advances at this edge; go to IDLE.
  - req_valid is ignored in RESP (same instruction still presented).
  - rdata holds its value until the next capture.
- Latency: issue cycle + ≥1 BUSY cycle + RESP; minimum 3 cycles when mem_ack arrives in the first BUSY cycle.
- Byte enables:
  - word: 1111
  - half: addr[1]=0 → 0011, addr[1]=1 → 1100
  - byte: 0001 << addr[1:0]
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load data: lane = mem_rdata >> (8*addr[1:0]); sign-extend from bit 7/15 unless req_unsigned.
- Reset mid-access: synchronous; mem_req drops at the reset edge; the pending ack is discarded.

Optional Feature:
DMEM_TIMEOUT_EN
- Defined: a counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT: drop mem_req, set rdata=0, pulse bus_err together with done in RESP.
  - mem_ack in the abort cycle is ignored.
- Undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

Decomposition:
- Package dmem_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (S_IDLE, S_BUSY, S_RESP)
  - functions byte_enable(size, addr_lo) and misaligned(size, addr_lo)
- Sub-module load_extend: combinational lane select plus sign/zero extension (mem_rdata, addr_lo, size, unsigned → N-bit result).

Test Plan:
- lw addr=0x0000_0104, mem_rdata=0xDEAD_BEEF, ack in first BUSY cycle → mem_be=1111, stall 2 cycles, done in cycle 3, rdata=0xDEAD_BEEF.
- lb addr=0x103, mem_rdata=0x80FF_0000 → rdata=0xFFFF_FF80; same access as lbu → rdata=0x0000_0080.
- sh addr=0x202, wdata=0x1234_ABCD, ack after 4 wait cycles → mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x200, stable across all BUSY cycles.
- lw addr=0x105 → misalign=1, stall=0, mem_req never asserted.
- reset asserted in second BUSY cycle → next cycle state IDLE, mem_req=0, done=0; a late mem_ack causes no done pulse.
- DMEM_TIMEOUT_EN, TIMEOUT=16, no ack → bus_err=1 and done=1 in the same cycle, 16 BUSY cycles after entry; rdata=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } state_e;

  // The reserved encoding 2'b11 behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input size_e sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension of the returned memory word.
module load_extend
  import dmem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] mem_rdata,
  input  logic [1:0]   addr_lo,
  input  size_e        size,
  input  logic         uns,
  output logic [N-1:0] result
);

  logic [N-1:0] lane;

  assign lane = mem_rdata >> {addr_lo, 3'b000};

  // Word accesses are always aligned, so the shifted lane equals the raw word.
  always_comb begin
    result = lane;
    case (size)
      SZ_BYTE: result = {{(N-8){lane[7] & ~uns}}, lane[7:0]};
      SZ_HALF: result = {{(N-16){lane[15] & ~uns}}, lane[15:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: issues one byte/half/word access, stalls the core
// until mem_ack, returns the extended load value. Optional abort on wait-state
// timeout is enabled with `define DMEM_TIMEOUT_EN.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         stall,
  output logic         done,
  output logic [N-1:0] rdata,
  output logic         misalign,
  output logic         bus_err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [3:0]   mem_be,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata
);

  state_e       state;
  size_e        req_sz, lat_size;
  logic         lat_uns;
  logic [1:0]   lat_lo;
  logic         req_mis, issue, abort;
  logic [N-1:0] st_data, ld_val;

  assign req_sz   = norm_size(req_size);
  assign req_mis  = misaligned(req_sz, addr[1:0]);
  assign misalign = (state == S_IDLE) && req_valid && req_mis;
  assign issue    = (state == S_IDLE) && req_valid && !req_mis;
  assign stall    = issue || (state == S_BUSY);

  always_comb begin
    st_data = wdata;
    case (req_sz)
      SZ_BYTE: st_data = {4{wdata[7:0]}};
      SZ_HALF: st_data = {2{wdata[15:0]}};
      default: st_data = wdata;
    endcase
  end

  load_extend #(.N(N)) u_ext (
    .mem_rdata (mem_rdata),
    .addr_lo   (lat_lo),
    .size      (lat_size),
    .uns       (lat_uns),
    .result    (ld_val)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // Abort wins over a same-cycle ack so a late ack can't race the error path.
  assign abort = (state == S_BUSY) && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || issue)                            to_cnt <= '0;
    else if (state == S_BUSY && !mem_ack && !abort) to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_size  <= SZ_BYTE;
      lat_uns   <= 1'b0;
      lat_lo    <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        S_IDLE: if (issue) begin
          lat_size  <= req_sz;
          lat_uns   <= req_unsigned;
          lat_lo    <= addr[1:0];
          mem_req   <= 1'b1;
          mem_we    <= req_we;
          mem_addr  <= {addr[N-1:2], 2'b00};
          mem_be    <= byte_enable(req_sz, addr[1:0]);
          mem_wdata <= st_data;
          state     <= S_BUSY;
        end
        S_BUSY: if (abort) begin
          mem_req <= 1'b0;
          rdata   <= '0;
          done    <= 1'b1;
          bus_err <= 1'b1;
          state   <= S_RESP;
        end else if (mem_ack) begin
          mem_req <= 1'b0;
          rdata   <= mem_we ? '0 : ld_val;
          done    <= 1'b1;
          state   <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
